mem_copy_ctrl: RTL and testbench



---
 rtl/mem_pkg.sv | 9 +
 rtl/mem_copy_timer.sv | 31 +++
 rtl/mem_copy_ctrl.sv | 148 ++++++++++++++
 tb/tb_mem_copy_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and constants for the memory4x4 copy controller
package mem_pkg;
  localparam int MEM_AW = 7;
  localparam logic [MEM_AW-1:0] ROM_BASE  = 7'h00;
  localparam logic [MEM_AW-1:0] SRAM_BASE = 7'h40;
  localparam int REGION_BIT = MEM_AW - 1;

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_e;
endpackage

// File: rtl/mem_copy_timer.sv
// rtl/mem_copy_timer.sv - phase down-counter; expire_o is high on the last cycle of a phase
module mem_copy_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         expire_o
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == '0);
endmodule

// File: rtl/mem_copy_ctrl.sv
// rtl/mem_copy_ctrl.sv - byte-serial memory4x4 copy engine (read phase, then held write phase)
// Optional MEM_COPY_CHECKSUM_EN adds a modulo-256 sum of every captured byte.
module mem_copy_ctrl
  import mem_pkg::*;
#(
  parameter int RD_LAT = 2,
  parameter int WR_CYC = 2,
  parameter int AW     = MEM_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] src_addr,
  input  logic [AW-1:0] dst_addr,
  input  logic [AW-1:0] len,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_din,
  input  logic [7:0]    mem_dout
`ifdef MEM_COPY_CHECKSUM_EN
  ,
  output logic [7:0]    checksum
`endif
);
  localparam int TW = 4;
  localparam logic [TW-1:0] RD_LOAD = TW'(RD_LAT - 1);
  localparam logic [TW-1:0] WR_LOAD = TW'(WR_CYC - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] src_q, src_d, dst_q, dst_d, cnt_q, cnt_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]    mem_din_q, mem_din_d;
  logic          busy_q, busy_d, done_q, done_d, err_q, err_d, mem_we_q, mem_we_d;
  logic          tmr_load, tmr_expire;
  logic [TW-1:0] tmr_val;
`ifdef MEM_COPY_CHECKSUM_EN
  logic [7:0]    chk_q, chk_d;
`endif

  mem_copy_timer #(.W(TW)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load_i    (tmr_load),
    .load_val_i(tmr_val),
    .expire_o  (tmr_expire)
  );

  // Every entry into RD or WR is a state change, so the timer reloads exactly then.
  assign tmr_load = (state_d != state_q) && (state_d == RD || state_d == WR);
  assign tmr_val  = (state_d == RD) ? RD_LOAD : WR_LOAD;

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    mem_din_d = mem_din_q;
`ifdef MEM_COPY_CHECKSUM_EN
    chk_d     = chk_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          src_d   = src_addr;
          dst_d   = dst_addr;
          cnt_d   = len;
          err_d   = 1'b0;
`ifdef MEM_COPY_CHECKSUM_EN
          chk_d   = 8'h00;
`endif
          state_d = (len == '0) ? DONE : RD;
        end
      end
      RD: begin
        if (tmr_expire) begin
          mem_din_d = mem_dout;
`ifdef MEM_COPY_CHECKSUM_EN
          chk_d     = chk_q + mem_dout;
`endif
          if (!dst_q[REGION_BIT]) err_d = 1'b1;
          state_d = WR;
        end
      end
      WR: begin
        if (tmr_expire) begin
          src_d   = src_q + 1'b1;
          dst_d   = dst_q + 1'b1;
          cnt_d   = cnt_q - 1'b1;
          state_d = (cnt_q == AW'(1)) ? DONE : RD;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d     = (state_d == RD) || (state_d == WR);
    done_d     = (state_d == DONE);
    mem_we_d   = (state_d == WR) && dst_d[REGION_BIT];
    mem_addr_d = mem_addr_q;
    if (state_d == RD) mem_addr_d = src_d;
    else if (state_d == WR) mem_addr_d = dst_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= 8'h00;
`ifdef MEM_COPY_CHECKSUM_EN
      chk_q      <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
`ifdef MEM_COPY_CHECKSUM_EN
      chk_q      <= chk_d;
`endif
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_din  = mem_din_q;
`ifdef MEM_COPY_CHECKSUM_EN
  assign checksum = chk_q;
`endif
endmodule

// File: tb/tb_mem_copy_ctrl.sv
// tb/tb_mem_copy_ctrl.sv - directed bench for mem_copy_ctrl against a memory4x4 model
module tb_mem_copy_ctrl;
  import mem_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [6:0] src_addr = '0, dst_addr = '0, len = '0;
  logic       busy, done, err, mem_we;
  logic [6:0] mem_addr;
  logic [7:0] mem_din;
  logic [7:0] mem_dout = 8'h00;
`ifdef MEM_COPY_CHECKSUM_EN
  logic [7:0] checksum;
`endif

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  int rom_we_cnt = 0;
  logic [7:0] rom  [64];
  logic [7:0] sram [64];
  logic [7:0] fib  [8];

  mem_copy_ctrl dut (
    .clk(clk), .rst(rst), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
    .busy(busy), .done(done), .err(err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
`ifdef MEM_COPY_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  // memory4x4 model: registered read, writes land only in SRAM
  always @(posedge clk) begin
    if (mem_we) begin
      we_cnt++;
      if (!mem_addr[REGION_BIT]) rom_we_cnt++;
      else sram[mem_addr[5:0]] <= mem_din;
    end
    mem_dout <= mem_addr[REGION_BIT] ? sram[mem_addr[5:0]] : rom[mem_addr[5:0]];
  end

  task automatic start_copy(input logic [6:0] s, input logic [6:0] d, input logic [6:0] l);
    @(negedge clk);
    src_addr = s; dst_addr = d; len = l; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_to_done(input int inject_at, output int bc, output int dc);
    bc = 0;
    dc = 0;
    for (int i = 0; i < 1000; i++) begin
      if (i == inject_at) begin
        start = 1'b1; src_addr = 7'h20; dst_addr = 7'h60; len = 7'd3;
      end else begin
        start = 1'b0;
      end
      if (busy) bc++;
      if (done) begin
        dc++;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", mem_we); end
    checks++; if (mem_addr !== 7'h00) begin errors++; $display("FAIL reset_addr: got %h expected 00", mem_addr); end
    checks++; if (mem_din !== 8'h00) begin errors++; $display("FAIL reset_din: got %h expected 00", mem_din); end
`ifdef MEM_COPY_CHECKSUM_EN
    checks++; if (checksum !== 8'h00) begin errors++; $display("FAIL reset_checksum: got %h expected 00", checksum); end
`endif
  endtask

  task automatic test_copy_rom_to_sram();
    int bc, dc;
    we_cnt = 0; rom_we_cnt = 0;
    start_copy(7'h00, 7'h40, 7'd8);
    run_to_done(-1, bc, dc);
    checks++; if (dc != 1) begin errors++; $display("FAIL copy1_done: got %0d expected 1", dc); end
    checks++; if (bc != 32) begin errors++; $display("FAIL copy1_busy_cycles: got %0d expected 32", bc); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL copy1_err: got %b expected 0", err); end
`ifdef MEM_COPY_CHECKSUM_EN
    checks++; if (checksum !== 8'h36) begin errors++; $display("FAIL copy1_checksum: got %h expected 36", checksum); end
`endif
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL copy1_done_width: got %b expected 0", done); end
    checks++; if (we_cnt != 16) begin errors++; $display("FAIL copy1_we_cycles: got %0d expected 16", we_cnt); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (sram[i] !== fib[i]) begin errors++; $display("FAIL copy1_data[%0d]: got %0d expected %0d", i, sram[i], fib[i]); end
    end
  endtask

  task automatic test_rom_dst_wrap();
    int bc, dc;
    we_cnt = 0; rom_we_cnt = 0;
    start_copy(7'h08, 7'h7E, 7'd4);
    run_to_done(-1, bc, dc);
    checks++; if (dc != 1) begin errors++; $display("FAIL wrap_done: got %0d expected 1", dc); end
    checks++; if (bc != 16) begin errors++; $display("FAIL wrap_busy_cycles: got %0d expected 16", bc); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL wrap_err: got %b expected 1", err); end
`ifdef MEM_COPY_CHECKSUM_EN
    checks++; if (checksum !== 8'h14) begin errors++; $display("FAIL wrap_checksum: got %h expected 14", checksum); end
`endif
    repeat (2) @(negedge clk);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL wrap_err_sticky: got %b expected 1", err); end
    checks++; if (sram[6'h3E] !== 8'd2) begin errors++; $display("FAIL wrap_7E: got %0d expected 2", sram[6'h3E]); end
    checks++; if (sram[6'h3F] !== 8'd2) begin errors++; $display("FAIL wrap_7F: got %0d expected 2", sram[6'h3F]); end
    checks++; if (rom_we_cnt != 0) begin errors++; $display("FAIL wrap_rom_we: got %0d expected 0", rom_we_cnt); end
    checks++; if (we_cnt != 4) begin errors++; $display("FAIL wrap_we_cycles: got %0d expected 4", we_cnt); end
  endtask

  task automatic test_len_zero();
    we_cnt = 0;
    start_copy(7'h00, 7'h40, 7'd0);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL len0_done: got %b expected 1", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL len0_busy: got %b expected 0", busy); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL len0_err_clear: got %b expected 0", err); end
`ifdef MEM_COPY_CHECKSUM_EN
    checks++; if (checksum !== 8'h00) begin errors++; $display("FAIL len0_checksum: got %h expected 00", checksum); end
`endif
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL len0_done_width: got %b expected 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL len0_busy_after: got %b expected 0", busy); end
    repeat (2) @(negedge clk);
    checks++; if (we_cnt != 0) begin errors++; $display("FAIL len0_we: got %0d expected 0", we_cnt); end
  endtask

  task automatic test_start_ignored();
    int bc, dc;
    we_cnt = 0;
    start_copy(7'h00, 7'h50, 7'd6);
    run_to_done(5, bc, dc);
    checks++; if (dc != 1) begin errors++; $display("FAIL ign_done: got %0d expected 1", dc); end
    checks++; if (bc != 24) begin errors++; $display("FAIL ign_busy_cycles: got %0d expected 24", bc); end
`ifdef MEM_COPY_CHECKSUM_EN
    checks++; if (checksum !== 8'h14) begin errors++; $display("FAIL ign_checksum: got %h expected 14", checksum); end
`endif
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_no_restart: got %b expected 0", busy); end
    checks++; if (we_cnt != 12) begin errors++; $display("FAIL ign_we_cycles: got %0d expected 12", we_cnt); end
    checks++; if (sram[6'h20] !== 8'hFF) begin errors++; $display("FAIL ign_60_untouched: got %h expected ff", sram[6'h20]); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (sram[6'h10 + i] !== fib[i]) begin errors++; $display("FAIL ign_data[%0d]: got %0d expected %0d", i, sram[6'h10 + i], fib[i]); end
    end
  endtask

  task automatic test_reset_mid_wr();
    int bc, dc;
    start_copy(7'h00, 7'h58, 7'd8);
    repeat (10) @(negedge clk);
    checks++; if (mem_we !== 1'b1 || mem_addr !== 7'h5A) begin
      errors++; $display("FAIL rstmid_in_wr3: got we=%b addr=%h expected we=1 addr=5a", mem_we, mem_addr);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if ({busy, done, err, mem_we} !== 4'b0000) begin
      errors++; $display("FAIL rstmid_flags: got %b expected 0000", {busy, done, err, mem_we});
    end
    checks++; if (mem_addr !== 7'h00 || mem_din !== 8'h00) begin
      errors++; $display("FAIL rstmid_bus: got addr=%h din=%h expected 00/00", mem_addr, mem_din);
    end
    repeat (3) @(negedge clk);
    checks++; if (sram[6'h1B] !== 8'hFF) begin errors++; $display("FAIL rstmid_no_byte4: got %h expected ff", sram[6'h1B]); end
    start_copy(7'h00, 7'h58, 7'd8);
    run_to_done(-1, bc, dc);
    checks++; if (dc != 1 || bc != 32) begin errors++; $display("FAIL rstmid_rerun: got done=%0d busy=%0d expected 1/32", dc, bc); end
    @(negedge clk);
    checks++; if (sram[6'h1F] !== 8'd21) begin errors++; $display("FAIL rstmid_rerun_5F: got %0d expected 21", sram[6'h1F]); end
  endtask

  task automatic test_sram_round_trip();
    int bc, dc;
    start_copy(7'h40, 7'h48, 7'd8);
    run_to_done(-1, bc, dc);
    checks++; if (dc != 1 || bc != 32) begin errors++; $display("FAIL sram_rt_timing: got done=%0d busy=%0d expected 1/32", dc, bc); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL sram_rt_err: got %b expected 0", err); end
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (sram[6'h08 + i] !== fib[i]) begin errors++; $display("FAIL sram_rt_data[%0d]: got %0d expected %0d", i, sram[6'h08 + i], fib[i]); end
    end
  endtask

  initial begin
    fib[0] = 8'd1; fib[1] = 8'd1; fib[2] = 8'd2;  fib[3] = 8'd3;
    fib[4] = 8'd5; fib[5] = 8'd8; fib[6] = 8'd13; fib[7] = 8'd21;
    for (int i = 0; i < 64; i++) begin
      rom[i]  = 8'h00;
      sram[i] = 8'hFF;
    end
    for (int i = 0; i < 8; i++) rom[i] = fib[i];
    rom[8] = 8'd2; rom[9] = 8'd2; rom[10] = 8'd7; rom[11] = 8'd9;

    test_reset();
    test_copy_rom_to_sram();
    test_rom_dst_wrap();
    test_len_zero();
    test_start_ignored();
    test_reset_mid_wr();
    test_sram_round_trip();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
